// File: rtl/decode_scoreboard.sv
// -----------------------------------------------------------------------------
// decode_scoreboard
//
// Decode stage with a register file, a per-register pending-write scoreboard
// and a branch-shadow counter. An instruction presented on I_VALID issues when
// it has no data hazard, no branch shadow is active and the output slot is
// free or being drained. Issue latches the PC, both source operands, the
// destination, and the sign-extended immediate into a registered output bundle.
//
// Optional feature (macro DECODE_WB_BYPASS_EN):
//   When defined, a writeback in the same cycle clears a source hazard whose
//   register has exactly one write outstanding. The issuing operand then takes
//   the writeback data directly. When undefined, the hazard lasts until the
//   edge after the writeback, which costs one extra stall cycle.
//
// Ports
//   I_CLOCK, I_RESET_N            clock, async active-low reset
//   I_VALID, I_PC                 presented instruction and its PC
//   I_SRC1_IDX/USE, I_SRC2_IDX/USE source register indices and read flags
//   I_DEST_IDX, I_DEST_WR         destination index and write flag
//   I_IS_BRANCH, I_IMM            control-flow flag, raw 16-bit immediate
//   I_OUT_READY                   execute stage accepts the output bundle
//   I_BR_RESOLVE                  branch resolved early, ends the shadow
//   I_WB_EN, I_WB_IDX, I_WB_DATA  register writeback
//   O_READY                       decode accepts the presented instruction
//   O_VALID, O_PC, O_SRC1, O_SRC2,
//   O_DEST_IDX, O_DEST_WR, O_IMM  registered issued bundle
//   O_CC                          {N,Z,P} of the most recent writeback
//   O_DEP_STALL, O_BR_STALL       hazard and branch-shadow indicators
//
// Handshake: the input side transfers on a rising edge where I_VALID and
// O_READY are both high; O_READY never depends on I_VALID. The output side
// transfers on a rising edge where O_VALID and I_OUT_READY are both high;
// while O_VALID is high and I_OUT_READY is low the bundle is held unchanged.
// -----------------------------------------------------------------------------
module decode_scoreboard #(
  parameter int REG_W    = 16,
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4,
  parameter int PC_W     = 16,
  parameter int PEND_W   = 2,
  parameter int BR_LAT   = 4
) (
  input  logic             I_CLOCK,
  input  logic             I_RESET_N,
  input  logic             I_VALID,
  input  logic [PC_W-1:0]  I_PC,
  input  logic [IDX_W-1:0] I_SRC1_IDX,
  input  logic [IDX_W-1:0] I_SRC2_IDX,
  input  logic             I_SRC1_USE,
  input  logic             I_SRC2_USE,
  input  logic [IDX_W-1:0] I_DEST_IDX,
  input  logic             I_DEST_WR,
  input  logic             I_IS_BRANCH,
  input  logic [15:0]      I_IMM,
  input  logic             I_OUT_READY,
  input  logic             I_BR_RESOLVE,
  input  logic             I_WB_EN,
  input  logic [IDX_W-1:0] I_WB_IDX,
  input  logic [REG_W-1:0] I_WB_DATA,
  output logic             O_READY,
  output logic             O_VALID,
  output logic [PC_W-1:0]  O_PC,
  output logic [REG_W-1:0] O_SRC1,
  output logic [REG_W-1:0] O_SRC2,
  output logic [IDX_W-1:0] O_DEST_IDX,
  output logic             O_DEST_WR,
  output logic [REG_W-1:0] O_IMM,
  output logic [2:0]       O_CC,
  output logic             O_DEP_STALL,
  output logic             O_BR_STALL
);

  // Storage is sized to the full index space. Entries at or above NUM_REGS
  // are never written, so they stay at their reset value of zero: reads of
  // such indices return 0 and their pending count never leaves 0.
  localparam int REGS_ALL = 2 ** IDX_W;
  localparam int BR_W     = $clog2(BR_LAT + 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
  localparam logic [BR_W-1:0]   BR_LOAD  = BR_W'(BR_LAT);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [REG_W-1:0]  rf_q   [REGS_ALL];
  logic [REG_W-1:0]  rf_d   [REGS_ALL];
  logic [PEND_W-1:0] pend_q [REGS_ALL];
  logic [PEND_W-1:0] pend_d [REGS_ALL];
  logic [BR_W-1:0]   br_cnt_q, br_cnt_d;

  logic              o_valid_q;
  logic [PC_W-1:0]   o_pc_q;
  logic [REG_W-1:0]  o_src1_q, o_src2_q;
  logic [IDX_W-1:0]  o_dest_idx_q;
  logic              o_dest_wr_q;
  logic [REG_W-1:0]  o_imm_q;
  logic [2:0]        o_cc_q;

  // ---------------------------------------------------------------------------
  // Index range qualification (constant per entry)
  // ---------------------------------------------------------------------------
  logic [REGS_ALL-1:0] idx_ok;

  for (genvar g = 0; g < REGS_ALL; g++) begin : g_idx_ok
    assign idx_ok[g] = (g < NUM_REGS);
  end

  // ---------------------------------------------------------------------------
  // Hazard detection and issue
  // ---------------------------------------------------------------------------
  logic             byp1, byp2;
  logic             src1_haz, src2_haz, dest_haz, hazard;
  logic             br_stall, ready, issue;
  logic [REG_W-1:0] src1_val, src2_val;
  logic [REG_W-1:0] imm_ext;
  logic [2:0]       cc_d;

`ifdef DECODE_WB_BYPASS_EN
  // A same-cycle writeback retires the only outstanding write to the source,
  // so the operand can be taken straight from the writeback bus.
  assign byp1 = I_WB_EN && idx_ok[I_WB_IDX] && (I_WB_IDX == I_SRC1_IDX) &&
                (pend_q[I_SRC1_IDX] == PEND_ONE);
  assign byp2 = I_WB_EN && idx_ok[I_WB_IDX] && (I_WB_IDX == I_SRC2_IDX) &&
                (pend_q[I_SRC2_IDX] == PEND_ONE);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign src1_haz = I_SRC1_USE && (pend_q[I_SRC1_IDX] != '0) && !byp1;
  assign src2_haz = I_SRC2_USE && (pend_q[I_SRC2_IDX] != '0) && !byp2;
  // A saturated counter cannot record one more write, so block the issue.
  assign dest_haz = I_DEST_WR && (pend_q[I_DEST_IDX] == PEND_MAX);
  assign hazard   = src1_haz || src2_haz || dest_haz;

  assign br_stall = (br_cnt_q != '0);
  assign ready    = !hazard && !br_stall && (!o_valid_q || I_OUT_READY);
  assign issue    = I_VALID && ready;

  // Without bypass the issuing read sees the register as it was before any
  // writeback landing on the same edge.
  assign src1_val = byp1 ? I_WB_DATA : rf_q[I_SRC1_IDX];
  assign src2_val = byp2 ? I_WB_DATA : rf_q[I_SRC2_IDX];
  assign imm_ext  = REG_W'($signed(I_IMM));

  always_comb begin
    cc_d = 3'b001;
    if (I_WB_DATA[REG_W-1]) begin
      cc_d = 3'b100;
    end else if (I_WB_DATA == '0) begin
      cc_d = 3'b010;
    end
  end

  // ---------------------------------------------------------------------------
  // Register file and scoreboard next state
  // ---------------------------------------------------------------------------
  logic inc_v, dec_v;

  always_comb begin
    inc_v = 1'b0;
    dec_v = 1'b0;
    for (int i = 0; i < REGS_ALL; i++) begin
      rf_d[i]   = rf_q[i];
      pend_d[i] = pend_q[i];
      inc_v = issue && I_DEST_WR && idx_ok[i] && (I_DEST_IDX == IDX_W'(i));
      dec_v = I_WB_EN && idx_ok[i] && (I_WB_IDX == IDX_W'(i));
      if (dec_v) begin
        rf_d[i] = I_WB_DATA;
      end
      // A same-edge increment and decrement cancel. A lone decrement at zero
      // is a stray writeback and leaves the count at zero.
      if (inc_v && !dec_v) begin
        pend_d[i] = pend_q[i] + PEND_ONE;
      end else if (dec_v && !inc_v && (pend_q[i] != '0)) begin
        pend_d[i] = pend_q[i] - PEND_ONE;
      end
    end
  end

  always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      for (int i = 0; i < REGS_ALL; i++) begin
        rf_q[i]   <= '0;
        pend_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < REGS_ALL; i++) begin
        rf_q[i]   <= rf_d[i];
        pend_q[i] <= pend_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Branch shadow counter
  // ---------------------------------------------------------------------------
  // Issue is blocked while the counter runs, so a branch load can only
  // coincide with a resolve pulse from an already-resolved branch; the new
  // branch's shadow takes precedence.
  always_comb begin
    br_cnt_d = br_cnt_q;
    if (issue && I_IS_BRANCH) begin
      br_cnt_d = BR_LOAD;
    end else if (I_BR_RESOLVE) begin
      br_cnt_d = '0;
    end else if (br_cnt_q != '0) begin
      br_cnt_d = br_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      br_cnt_q <= '0;
    end else begin
      br_cnt_q <= br_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output bundle and condition code
  // ---------------------------------------------------------------------------
  always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      o_valid_q    <= 1'b0;
      o_pc_q       <= '0;
      o_src1_q     <= '0;
      o_src2_q     <= '0;
      o_dest_idx_q <= '0;
      o_dest_wr_q  <= 1'b0;
      o_imm_q      <= '0;
      o_cc_q       <= 3'b010;
    end else begin
      if (issue) begin
        o_valid_q    <= 1'b1;
        o_pc_q       <= I_PC;
        o_src1_q     <= src1_val;
        o_src2_q     <= src2_val;
        o_dest_idx_q <= I_DEST_IDX;
        o_dest_wr_q  <= I_DEST_WR;
        o_imm_q      <= imm_ext;
      end else if (I_OUT_READY) begin
        // Bundle consumed with nothing to replace it; data fields keep their
        // last values, only the valid flag drops.
        o_valid_q <= 1'b0;
      end
      if (I_WB_EN) begin
        o_cc_q <= cc_d;
      end
    end
  end

  assign O_READY     = ready;
  assign O_VALID     = o_valid_q;
  assign O_PC        = o_pc_q;
  assign O_SRC1      = o_src1_q;
  assign O_SRC2      = o_src2_q;
  assign O_DEST_IDX  = o_dest_idx_q;
  assign O_DEST_WR   = o_dest_wr_q;
  assign O_IMM       = o_imm_q;
  assign O_CC        = o_cc_q;
  assign O_DEP_STALL = I_VALID && hazard;
  assign O_BR_STALL  = br_stall;

endmodule

// File: doc/decode_scoreboard.md
DECODE_SCOREBOARD -- requirements
Module: decode_scoreboard

Interface
REQ-001 Parameters SHALL be: REG_W 16 (register/data width); NUM_REGS 16 (register count); IDX_W 4 (register index width, 2**IDX_W >= NUM_REGS); PC_W 16 (PC width); PEND_W 2 (per-register pending-write counter width); BR_LAT 4 (branch stall cycles).
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low. Ports:
- I_CLOCK in 1: clock.
- I_RESET_N in 1: async active-low reset.
- I_VALID in 1: an instruction is presented.
- I_PC in PC_W: instruction PC.
- I_SRC1_IDX, I_SRC2_IDX in IDX_W: source register indices.
- I_SRC1_USE, I_SRC2_USE in 1: source is read.
- I_DEST_IDX in IDX_W: destination register index.
- I_DEST_WR in 1: instruction writes its destination.
- I_IS_BRANCH in 1: control-flow instruction.
- I_IMM in 16: raw immediate.
- I_OUT_READY in 1: execute stage accepts.
- I_BR_RESOLVE in 1: branch resolved early.
- I_WB_EN in 1: writeback valid.
- I_WB_IDX in IDX_W: writeback register index.
- I_WB_DATA in REG_W: writeback data.
- O_READY out 1: decode accepts this cycle.
- O_VALID out 1: output bundle valid.
- O_PC out PC_W: issued PC.
- O_SRC1, O_SRC2 out REG_W: operand values.
- O_DEST_IDX out IDX_W: issued destination index.
- O_DEST_WR out 1: issued instruction writes its destination.
- O_IMM out REG_W: sign-extended immediate.
- O_CC out 3: condition code {N,Z,P}.
- O_DEP_STALL out 1: data hazard this cycle.
- O_BR_STALL out 1: branch shadow active.

Function
REQ-003 Hazard SHALL be combinational: (I_SRC1_USE and pend[I_SRC1_IDX]!=0) or (I_SRC2_USE and pend[I_SRC2_IDX]!=0) or (I_DEST_WR and pend[I_DEST_IDX] saturated at 2**PEND_W-1).
REQ-004 O_DEP_STALL SHALL equal I_VALID and hazard.
REQ-005 O_BR_STALL SHALL equal (br_cnt != 0).
REQ-006 O_READY SHALL equal not hazard, not O_BR_STALL, and (not O_VALID or I_OUT_READY).
REQ-007 An issue SHALL occur on a rising edge with I_VALID and O_READY. Latency is 1 cycle: registered outputs capture PC, RF[src] values, dest, sign-extended I_IMM, and O_VALID is set to 1.
REQ-008 If O_VALID=1 and I_OUT_READY=0, all O_ bundle outputs SHALL hold stable.
REQ-009 If O_VALID=1, I_OUT_READY=1 and there is no issue, O_VALID SHALL clear to 0.
REQ-010 On issue with I_DEST_WR=1, pend[I_DEST_IDX] SHALL increment by 1.
REQ-011 On I_WB_EN=1, RF[I_WB_IDX] SHALL be written with I_WB_DATA and pend[I_WB_IDX] SHALL decrement by 1. A decrement at 0 SHALL saturate at 0.
REQ-012 Simultaneous increment and decrement on the same index SHALL leave the count unchanged.
REQ-013 On I_WB_EN=1, O_CC SHALL update on the same edge: 100 if I_WB_DATA[REG_W-1]=1, 010 if I_WB_DATA=0, else 001.
REQ-014 Issue of an instruction with I_IS_BRANCH=1 SHALL load br_cnt with BR_LAT.
REQ-015 br_cnt SHALL decrement by 1 per cycle while nonzero, and SHALL clear to 0 on I_BR_RESOLVE=1. Issue is blocked while br_cnt is nonzero.
REQ-016 Writeback and issue on the same edge SHALL both take effect. Without bypass, the read returns the pre-write RF value.
REQ-017 Index values >= NUM_REGS SHALL be treated as no-ops for writes and SHALL read as 0.

Reset
REQ-018 While I_RESET_N=0, asynchronously: all RF entries SHALL be 0; all pend SHALL be 0; br_cnt SHALL be 0; O_CC SHALL be 010; O_VALID, O_PC, O_SRC1, O_SRC2, O_DEST_IDX, O_DEST_WR and O_IMM SHALL be 0.
REQ-019 Reset asserted mid-branch-shadow or with pending writes SHALL discard all state. Writebacks arriving after reset SHALL saturate pend at 0 (REQ-011).

Configuration
REQ-020 With DECODE_WB_BYPASS_EN defined: a source whose index equals I_WB_IDX with I_WB_EN=1 and pend==1 SHALL NOT count as a hazard, and its operand SHALL take I_WB_DATA in the same cycle.
REQ-021 Without DECODE_WB_BYPASS_EN: the hazard SHALL persist until the edge after writeback, adding one stall cycle.

Verification
REQ-022 Reset, then issue src1=R3 (RF=0), I_OUT_READY=1 -> next cycle O_VALID=1, O_SRC1=0, O_CC=010.
REQ-023 Issue dest R2 (pend[2]=1), then present src1=R2 -> O_DEP_STALL=1 and O_READY=0. Writeback R2=0x8000 -> O_CC=100; R2 issues with O_SRC1=0x8000, one cycle earlier with DECODE_WB_BYPASS_EN than without.
REQ-024 Issue a branch, BR_LAT=4, I_BR_RESOLVE=0 -> O_BR_STALL high for exactly 4 cycles, no issue during it. Repeat with I_BR_RESOLVE at cycle 2 -> O_BR_STALL drops after 2 cycles.
REQ-025 Issue dest R5 three times with PEND_W=2 -> the fourth issue to R5 stalls until any R5 writeback. Same-edge issue and writeback of R5 -> pend[5] unchanged.
REQ-026 I_OUT_READY=0 for 3 cycles with O_VALID=1 -> outputs stable and O_READY=0. Assert I_RESET_N=0 mid-sequence -> all outputs zero immediately, O_CC=010.
